tx_scheduler: RTL and testbench

TX_SCHEDULER -- requirements
Module: tx_scheduler

---
 rtl/tx_scheduler_pkg.sv | 41 ++++
 rtl/tx_scheduler.sv | 154 +++++++++++++++
 tb/tb_tx_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_scheduler_pkg.sv
// Shared constants, state encoding and stat snapshot type for the pet status transmitter.
package tx_scheduler_pkg;

    localparam logic [7:0]  TYPE_REPORT       = 8'h01;
    localparam logic [7:0]  TYPE_ACK          = 8'h02;
    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int unsigned STAT_W            = 5;
    localparam int unsigned REPORT_BYTES      = 6;
    localparam int unsigned TICK_CNT_W        = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_TYPE    = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CSUM    = 3'd4
    } state_t;

    typedef struct packed {
        logic [STAT_W-1:0] hunger;
        logic [STAT_W-1:0] happiness;
        logic [STAT_W-1:0] hygiene;
        logic [STAT_W-1:0] energy;
        logic [STAT_W-1:0] social;
        logic              is_sleeping;
    } stats_t;

    // Report payload byte selected by index, each stat zero-extended to a byte.
    function automatic logic [7:0] report_byte(input stats_t s, input logic [2:0] idx);
        case (idx)
            3'd0:    report_byte = 8'(s.hunger);
            3'd1:    report_byte = 8'(s.happiness);
            3'd2:    report_byte = 8'(s.hygiene);
            3'd3:    report_byte = 8'(s.energy);
            3'd4:    report_byte = 8'(s.social);
            3'd5:    report_byte = 8'(s.is_sleeping);
            default: report_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/tx_scheduler.sv
// Frames periodic stat reports and acknowledge codes into a byte stream for a UART transmitter.
module tx_scheduler
    import tx_scheduler_pkg::*;
#(
    parameter int unsigned REPORT_EVERY = 4,
    parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [STAT_W-1:0] hunger,
    input  logic [STAT_W-1:0] happiness,
    input  logic [STAT_W-1:0] hygiene,
    input  logic [STAT_W-1:0] energy,
    input  logic [STAT_W-1:0] social,
    input  logic              is_sleeping,
    input  logic              ack_req,
    input  logic [7:0]        ack_code,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              dropped
);

    localparam logic [TICK_CNT_W-1:0] PERIOD   = TICK_CNT_W'(REPORT_EVERY);
    localparam logic [2:0]            LAST_IDX = 3'(REPORT_BYTES - 1);

    state_t                  state;
    logic [TICK_CNT_W-1:0]   tick_cnt;
    logic                    report_pending;
    logic                    ack_pending;
    logic [7:0]              ack_code_q;
    logic [7:0]              frame_code;
    logic [7:0]              csum_q;
    stats_t                  snap;
    logic                    frame_is_ack;
    logic [2:0]              idx;

    logic       hs_c;
    logic       take_ack_c;
    logic       take_report_c;
    logic       period_done_c;
    logic       last_payload_c;
    logic [7:0] first_payload_c;
    logic [7:0] next_payload_c;

    assign hs_c            = tx_valid && tx_ready;
    assign take_ack_c      = (state == ST_IDLE) && ack_pending;
    assign take_report_c   = (state == ST_IDLE) && !ack_pending && report_pending;
    assign period_done_c   = tick && ((tick_cnt + TICK_CNT_W'(1)) == PERIOD);
    assign last_payload_c  = frame_is_ack || (idx == LAST_IDX);
    assign first_payload_c = frame_is_ack ? frame_code : report_byte(snap, 3'd0);
    assign next_payload_c  = report_byte(snap, 3'(idx + 3'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            tx_valid       <= 1'b0;
            tx_data        <= 8'h00;
            busy           <= 1'b0;
            dropped        <= 1'b0;
            tick_cnt       <= '0;
            report_pending <= 1'b0;
            ack_pending    <= 1'b0;
            ack_code_q     <= 8'h00;
            frame_code     <= 8'h00;
            csum_q         <= 8'h00;
            snap           <= '0;
            frame_is_ack   <= 1'b0;
            idx            <= 3'd0;
        end else begin
            // An ack being launched this cycle is not lost, so only a true overwrite counts.
            dropped <= ack_req && ack_pending && !take_ack_c;

            if (tick) begin
                tick_cnt <= period_done_c ? '0 : tick_cnt + TICK_CNT_W'(1);
            end

            if (period_done_c) begin
                report_pending <= 1'b1;
            end else if (take_report_c) begin
                report_pending <= 1'b0;
            end

            if (ack_req) begin
                ack_pending <= 1'b1;
                ack_code_q  <= ack_code;
            end else if (take_ack_c) begin
                ack_pending <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (take_ack_c || take_report_c) begin
                        state        <= ST_SYNC;
                        busy         <= 1'b1;
                        tx_valid     <= 1'b1;
                        tx_data      <= SYNC_BYTE;
                        frame_is_ack <= take_ack_c;
                        csum_q       <= 8'h00;
                        idx          <= 3'd0;
                        if (take_ack_c) begin
                            frame_code <= ack_code_q;
                        end else begin
                            snap <= {hunger, happiness, hygiene, energy, social, is_sleeping};
                        end
                    end
                end
                ST_SYNC: begin
                    if (hs_c) begin
                        state   <= ST_TYPE;
                        tx_data <= frame_is_ack ? TYPE_ACK : TYPE_REPORT;
                    end
                end
                ST_TYPE: begin
                    if (hs_c) begin
                        state   <= ST_PAYLOAD;
                        csum_q  <= tx_data;
                        tx_data <= first_payload_c;
                    end
                end
                ST_PAYLOAD: begin
                    // Checksum accumulates each accepted byte; the final XOR folds in the last one.
                    if (hs_c) begin
                        csum_q <= csum_q ^ tx_data;
                        if (last_payload_c) begin
                            state   <= ST_CSUM;
                            tx_data <= csum_q ^ tx_data;
                        end else begin
                            idx     <= 3'(idx + 3'd1);
                            tx_data <= next_payload_c;
                        end
                    end
                end
                ST_CSUM: begin
                    if (hs_c) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        tx_valid <= 1'b0;
                        tx_data  <= 8'h00;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    tx_valid <= 1'b0;
                    tx_data  <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed bench for tx_scheduler: frame contents, backpressure, ack overwrite, ordering and reset.
module tb_tx_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [4:0] hunger;
    logic [4:0] happiness;
    logic [4:0] hygiene;
    logic [4:0] energy;
    logic [4:0] social;
    logic       is_sleeping;
    logic       ack_req;
    logic [7:0] ack_code;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       dropped;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] cap [16];
    int         cap_n;
    int         cap_busy;

    tx_scheduler #(
        .REPORT_EVERY(4),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .hunger     (hunger),
        .happiness  (happiness),
        .hygiene    (hygiene),
        .energy     (energy),
        .social     (social),
        .is_sleeping(is_sleeping),
        .ack_req    (ack_req),
        .ack_code   (ack_code),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .dropped    (dropped)
    );

    always #5 clk = ~clk;

    task automatic set_stats(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                             input logic [4:0] d, input logic [4:0] e, input logic s);
        hunger = a; happiness = b; hygiene = c; energy = d; social = e; is_sleeping = s;
    endtask

    task automatic tick_pulse();
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
    endtask

    task automatic ack_pulse(input logic [7:0] code);
        @(negedge clk); ack_req = 1'b1; ack_code = code;
        @(negedge clk); ack_req = 1'b0;
    endtask

    // Records accepted bytes until max_bytes are seen or the cycle budget runs out.
    task automatic capture(input int max_bytes, input int budget);
        for (int i = 0; i < 16; i++) cap[i] = 8'hxx;
        cap_n = 0;
        cap_busy = 0;
        for (int c = 0; c < budget && cap_n < max_bytes; c++) begin
            @(negedge clk);
            if (busy) cap_busy++;
            if (tx_valid && tx_ready) begin
                cap[cap_n] = tx_data;
                cap_n++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; tick = 1'b0; ack_req = 1'b0; ack_code = 8'h00; tx_ready = 1'b1;
        set_stats(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({tx_valid, busy, dropped, tx_data} !== 11'h000) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid=%b busy=%b dropped=%b data=%h expected all zero",
                     tx_valid, busy, dropped, tx_data);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: got valid=%b busy=%b expected 0 0", tx_valid, busy);
        end
    endtask

    task automatic test_report();
        logic [7:0] exp [9];
        // Checksum folds in the type byte and all six payload bytes including the sleep byte.
        exp = '{8'hA5, 8'h01, 8'h03, 8'h07, 8'h1F, 8'h00, 8'h10, 8'h01, 8'h0B};
        set_stats(5'd3, 5'd7, 5'd31, 5'd0, 5'd16, 1'b1);
        repeat (3) tick_pulse();
        n_cmp++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL report_early: got valid=%b busy=%b after 3 ticks expected 0 0", tx_valid, busy);
        end
        tick_pulse();
        capture(9, 30);
        n_cmp++;
        if (cap_n !== 9) begin
            n_bad++;
            $display("FAIL report_len: got %0d bytes expected 9", cap_n);
        end
        for (int i = 0; i < 9; i++) begin
            n_cmp++;
            if (cap[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL report_byte[%0d]: got %h expected %h", i, cap[i], exp[i]);
            end
        end
        n_cmp++;
        if (cap_busy !== 9) begin
            n_bad++;
            $display("FAIL report_busy_cycles: got %0d expected 9", cap_busy);
        end
    endtask

    task automatic test_ack();
        logic [7:0] exp [4];
        exp = '{8'hA5, 8'h02, 8'h5C, 8'h5E};
        ack_pulse(8'h5C);
        capture(4, 20);
        n_cmp++;
        if (cap_n !== 4) begin
            n_bad++;
            $display("FAIL ack_len: got %0d bytes expected 4", cap_n);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (cap[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL ack_byte[%0d]: got %h expected %h", i, cap[i], exp[i]);
            end
        end
        n_cmp++;
        if (cap_busy !== 4) begin
            n_bad++;
            $display("FAIL ack_busy_cycles: got %0d expected 4", cap_busy);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL ack_done: got busy=%b valid=%b expected 0 0", busy, tx_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [7];
        exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h00, 8'h1E};
        set_stats(5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 1'b0);
        repeat (4) tick_pulse();
        for (int c = 0; c < 10 && !tx_valid; c++) @(negedge clk);
        n_cmp++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            n_bad++;
            $display("FAIL bp_sync: got valid=%b data=%h expected 1 a5", tx_valid, tx_data);
        end
        @(negedge clk);
        tx_ready = 1'b0;
        set_stats(5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got valid=%b data=%h expected 1 01", i, tx_valid, tx_data);
            end
        end
        tx_ready = 1'b1;
        capture(7, 20);
        n_cmp++;
        if (cap_n !== 7) begin
            n_bad++;
            $display("FAIL bp_len: got %0d bytes expected 7", cap_n);
        end
        for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if (cap[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL bp_byte[%0d]: got %h expected %h", i, cap[i], exp[i]);
            end
        end
    endtask

    task automatic test_ack_overwrite();
        logic [7:0] exp [13];
        int start;
        int n_drop;
        exp = '{8'hA5, 8'h01, 8'h03, 8'h07, 8'h1F, 8'h00, 8'h10, 8'h01, 8'h0B,
                8'hA5, 8'h02, 8'h22, 8'h20};
        set_stats(5'd3, 5'd7, 5'd31, 5'd0, 5'd16, 1'b1);
        repeat (4) tick_pulse();
        for (int i = 0; i < 16; i++) cap[i] = 8'hxx;
        cap_n = 0;
        start = -1;
        n_drop = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dropped) n_drop++;
            if (tx_valid && tx_ready && cap_n < 16) begin
                cap[cap_n] = tx_data;
                cap_n++;
            end
            if (start < 0 && tx_valid) start = c;
            ack_req = 1'b0;
            if (start >= 0 && c == start + 1) begin ack_req = 1'b1; ack_code = 8'h11; end
            if (start >= 0 && c == start + 3) begin ack_req = 1'b1; ack_code = 8'h22; end
        end
        n_cmp++;
        if (n_drop !== 1) begin
            n_bad++;
            $display("FAIL drop_pulses: got %0d expected 1", n_drop);
        end
        n_cmp++;
        if (cap_n !== 13) begin
            n_bad++;
            $display("FAIL drop_len: got %0d bytes expected 13", cap_n);
        end
        for (int i = 0; i < 13; i++) begin
            n_cmp++;
            if (cap[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL drop_byte[%0d]: got %h expected %h", i, cap[i], exp[i]);
            end
        end
    endtask

    task automatic test_tick_and_ack();
        logic [7:0] exp [13];
        int cyc [16];
        exp = '{8'hA5, 8'h02, 8'h33, 8'h31,
                8'hA5, 8'h01, 8'h03, 8'h07, 8'h1F, 8'h00, 8'h10, 8'h01, 8'h0B};
        repeat (3) tick_pulse();
        @(negedge clk); tick = 1'b1; ack_req = 1'b1; ack_code = 8'h33;
        @(negedge clk); tick = 1'b0; ack_req = 1'b0;
        for (int i = 0; i < 16; i++) begin cap[i] = 8'hxx; cyc[i] = 0; end
        cap_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (tx_valid && tx_ready && cap_n < 16) begin
                cap[cap_n] = tx_data;
                cyc[cap_n] = c;
                cap_n++;
            end
        end
        n_cmp++;
        if (cap_n !== 13) begin
            n_bad++;
            $display("FAIL both_len: got %0d bytes expected 13", cap_n);
        end
        for (int i = 0; i < 13; i++) begin
            n_cmp++;
            if (cap[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL both_byte[%0d]: got %h expected %h", i, cap[i], exp[i]);
            end
        end
        n_cmp++;
        if (cyc[4] - cyc[3] !== 2) begin
            n_bad++;
            $display("FAIL both_gap: got %0d cycles between frames expected 2", cyc[4] - cyc[3]);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] exp [4];
        int n_valid;
        exp = '{8'hA5, 8'h02, 8'h7E, 8'h7C};
        repeat (4) tick_pulse();
        for (int c = 0; c < 10 && !tx_valid; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h07) begin
            n_bad++;
            $display("FAIL rst_pre: got valid=%b data=%h expected 1 07", tx_valid, tx_data);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({tx_valid, busy, tx_data} !== 10'h000) begin
            n_bad++;
            $display("FAIL rst_mid: got valid=%b busy=%b data=%h expected 0 0 00", tx_valid, busy, tx_data);
        end
        reset = 1'b0;
        n_valid = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tx_valid) n_valid++;
        end
        n_cmp++;
        if (n_valid !== 0) begin
            n_bad++;
            $display("FAIL rst_quiet: got %0d valid cycles expected 0", n_valid);
        end
        ack_pulse(8'h7E);
        capture(4, 20);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (cap[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL rst_after_byte[%0d]: got %h expected %h", i, cap[i], exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_report();
        test_ack();
        test_backpressure();
        test_ack_overwrite();
        test_tick_and_ack();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
